// File: rtl/clamp_sched.sv
// Round-robin arbiter feeding a shared two-stage signed saturating clamp,
// with per-channel saturation event counters.
module clamp_sched #(
  parameter int NCH  = 4,
  parameter int CHW  = 2,
  parameter int INW  = 16,
  parameter int OUTW = 8,
  parameter int CNTW = 8
) (
  input  logic                clk,
  input  logic                i_nrst,
  input  logic [NCH-1:0]      req_valid,
  input  logic [NCH*INW-1:0]  req_data,
  output logic [NCH-1:0]      req_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUTW-1:0]     out_data,
  output logic [CHW-1:0]      out_ch,
  output logic                out_sat,
  input  logic                clr_cnt,
  output logic [NCH*CNTW-1:0] sat_cnt
);

  localparam logic [OUTW-1:0] CLAMP_MAX = {1'b0, {(OUTW-1){1'b1}}};
  localparam logic [OUTW-1:0] CLAMP_MIN = {1'b1, {(OUTW-1){1'b0}}};

  // Handshake: a word moves on channel k in a cycle where req_valid[k] and
  // req_ready[k] are both high at the rising edge; out_* likewise moves on
  // out_valid && out_ready. Producers hold req_data stable until accepted.

  logic [CHW-1:0]  ptr;
  logic            advance;
  logic            grant_found;
  logic [CHW-1:0]  grant_ch;
  logic [CHW-1:0]  search_idx;
  logic            xfer;
  logic [INW-1:0]  grant_word;

  logic            s1_valid;
  logic [INW-1:0]  s1_data;
  logic [CHW-1:0]  s1_ch;

  logic [OUTW-1:0] clamp_res;
  logic            clamp_sat;
  logic            cnt_inc;
  logic [CNTW-1:0] cnt_q [NCH];

  // The whole pipeline stalls only when a held output is refused.
  assign advance = !(out_valid && !out_ready);

  always_comb begin
    grant_found = 1'b0;
    grant_ch    = '0;
    search_idx  = '0;
    for (int i = 0; i < NCH; i++) begin
      search_idx = ptr + CHW'(i);
      if (!grant_found && req_valid[search_idx]) begin
        grant_found = 1'b1;
        grant_ch    = search_idx;
      end
    end
  end

  assign xfer       = grant_found && advance;
  assign req_ready  = xfer ? (NCH'(1) << grant_ch) : '0;
  assign grant_word = req_data[grant_ch*INW +: INW];

  always_ff @(posedge clk or negedge i_nrst) begin
    if (!i_nrst) begin
      ptr <= '0;
    end else if (xfer) begin
      ptr <= grant_ch + CHW'(1);
    end
  end

  always_ff @(posedge clk or negedge i_nrst) begin
    if (!i_nrst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_ch    <= '0;
    end else if (advance) begin
      s1_valid <= xfer;
      s1_data  <= grant_word;
      s1_ch    <= grant_ch;
    end
  end

  // In range exactly when the discarded upper bits are a sign extension.
  always_comb begin
    clamp_res = s1_data[OUTW-1:0];
    clamp_sat = 1'b0;
    if (!((&s1_data[INW-1:OUTW-1]) || !(|s1_data[INW-1:OUTW-1]))) begin
      clamp_sat = 1'b1;
      clamp_res = s1_data[INW-1] ? CLAMP_MIN : CLAMP_MAX;
    end
  end

  always_ff @(posedge clk or negedge i_nrst) begin
    if (!i_nrst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      out_sat   <= 1'b0;
    end else if (advance) begin
      out_valid <= s1_valid;
      out_data  <= clamp_res;
      out_ch    <= s1_ch;
      out_sat   <= clamp_sat;
    end
  end

  assign cnt_inc = advance && s1_valid && clamp_sat;

  // Counters saturate at all-ones; clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge i_nrst) begin
    if (!i_nrst) begin
      for (int k = 0; k < NCH; k++) cnt_q[k] <= '0;
    end else if (clr_cnt) begin
      for (int k = 0; k < NCH; k++) cnt_q[k] <= '0;
    end else if (cnt_inc && (cnt_q[s1_ch] != {CNTW{1'b1}})) begin
      cnt_q[s1_ch] <= cnt_q[s1_ch] + CNTW'(1);
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_cnt_out
    assign sat_cnt[g*CNTW +: CNTW] = cnt_q[g];
  end

endmodule

// File: tb/tb_clamp_sched.sv
// Directed bench for clamp_sched: vector table of single-word transfers plus
// hand-written round-robin, backpressure, counter and reset sequences.
module tb_clamp_sched;

  logic        clk;
  logic        i_nrst;
  logic [3:0]  req_valid;
  logic [63:0] req_data;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_sat;
  logic        clr_cnt;
  logic [31:0] sat_cnt;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    logic [1:0]  ch;
    logic [15:0] word;
    logic [7:0]  exp_data;
    logic        exp_sat;
  } vec_t;

  vec_t vecs [10];

  clamp_sched dut (
    .clk       (clk),
    .i_nrst    (i_nrst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_sat   (out_sat),
    .clr_cnt   (clr_cnt),
    .sat_cnt   (sat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] cnt_of(input int k);
    return {24'd0, sat_cnt[k*8 +: 8]};
  endfunction

  // One word on one channel, idle pipeline, out_ready=1.
  task automatic apply_vec(input vec_t v);
    @(negedge clk);
    req_valid = 4'b0001 << v.ch;
    req_data[v.ch*16 +: 16] = v.word;
    #1;
    check("vec_ready", {28'd0, req_ready}, {28'd0, 4'b0001 << v.ch});
    @(negedge clk);
    req_valid = 4'b0000;
    check("vec_latency", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check("vec_valid", {31'd0, out_valid}, 32'd1);
    check("vec_data", {24'd0, out_data}, {24'd0, v.exp_data});
    check("vec_ch", {30'd0, out_ch}, {30'd0, v.ch});
    check("vec_sat", {31'd0, out_sat}, {31'd0, v.exp_sat});
  endtask

  initial begin
    vecs[0] = '{2'd0, 16'h007F, 8'h7F, 1'b0};
    vecs[1] = '{2'd0, 16'hFF80, 8'h80, 1'b0};
    vecs[2] = '{2'd0, 16'h0000, 8'h00, 1'b0};
    vecs[3] = '{2'd1, 16'h0080, 8'h7F, 1'b1};
    vecs[4] = '{2'd1, 16'h7FFF, 8'h7F, 1'b1};
    vecs[5] = '{2'd2, 16'hFF7F, 8'h80, 1'b1};
    vecs[6] = '{2'd2, 16'h8000, 8'h80, 1'b1};
    vecs[7] = '{2'd3, 16'h0001, 8'h01, 1'b0};
    vecs[8] = '{2'd3, 16'hFFFF, 8'hFF, 1'b0};
    vecs[9] = '{2'd3, 16'h00FF, 8'h7F, 1'b1};

    i_nrst    = 1'b0;
    req_valid = 4'b0000;
    req_data  = 64'd0;
    out_ready = 1'b1;
    clr_cnt   = 1'b0;
    repeat (3) @(negedge clk);
    i_nrst = 1'b1;
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    check("rst_out_ch", {30'd0, out_ch}, 32'd0);
    check("rst_out_sat", {31'd0, out_sat}, 32'd0);
    check("rst_sat_cnt", sat_cnt, 32'd0);
    check("rst_req_ready", {28'd0, req_ready}, 32'd0);

    for (int i = 0; i < 10; i++) apply_vec(vecs[i]);
    check("cnt_ch0", cnt_of(0), 32'd0);
    check("cnt_ch1", cnt_of(1), 32'd2);
    check("cnt_ch2", cnt_of(2), 32'd2);
    check("cnt_ch3", cnt_of(3), 32'd1);

    // Round robin: pointer is 0 after the last ch3 transfer.
    @(negedge clk);
    req_valid = 4'b1111;
    req_data  = {16'd3, 16'd2, 16'd1, 16'd0};
    for (int i = 0; i < 9; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      check("rr_grant", {28'd0, req_ready}, 32'(1) << (i % 4));
      if (i >= 2) begin
        check("rr_out_valid", {31'd0, out_valid}, 32'd1);
        check("rr_out_ch", {30'd0, out_ch}, 32'((i - 2) % 4));
        check("rr_out_data", {24'd0, out_data}, 32'((i - 2) % 4));
      end
    end
    @(negedge clk);
    req_valid = 4'b1000;
    #1;
    check("rr_ch3_only", {28'd0, req_ready}, 32'h8);
    @(negedge clk);
    req_valid = 4'b0000;
    repeat (3) @(negedge clk);

    // Backpressure with ch0 and ch2; pointer is 0 here.
    req_valid = 4'b0101;
    req_data  = {16'd0, 16'h0020, 16'd0, 16'h0010};
    #1;
    check("bp_grant0", {28'd0, req_ready}, 32'h1);
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    check("bp_bubble_grant", {28'd0, req_ready}, 32'h4);
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      check("bp_hold_ch", {30'd0, out_ch}, 32'd0);
      check("bp_hold_data", {24'd0, out_data}, 32'h10);
      check("bp_hold_ready", {28'd0, req_ready}, 32'd0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_resume_grant", {28'd0, req_ready}, 32'h1);
    @(negedge clk);
    check("bp_out1_ch", {30'd0, out_ch}, 32'd2);
    check("bp_out1_data", {24'd0, out_data}, 32'h20);
    check("bp_grant2", {28'd0, req_ready}, 32'h4);
    @(negedge clk);
    req_valid = 4'b0000;
    check("bp_out2_ch", {30'd0, out_ch}, 32'd0);
    check("bp_out2_valid", {31'd0, out_valid}, 32'd1);
    @(negedge clk);
    check("bp_out3_ch", {30'd0, out_ch}, 32'd2);
    check("bp_out3_valid", {31'd0, out_valid}, 32'd1);
    @(negedge clk);
    check("bp_drained", {31'd0, out_valid}, 32'd0);

    // Counter clear, saturation at 8'hFF, clear beating an increment.
    clr_cnt = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
    check("clr_all", sat_cnt, 32'd0);
    req_valid = 4'b0001;
    req_data  = 64'h0000_0000_0000_1000;
    for (int i = 0; i < 302; i++) @(negedge clk);
    check("cnt0_sat_ff", cnt_of(0), 32'hFF);
    check("cnt1_untouched", cnt_of(1), 32'd0);
    check("sat_stream_out", {24'd0, out_data}, 32'h7F);
    clr_cnt = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
    check("clr_over_inc", cnt_of(0), 32'd0);
    @(negedge clk);
    check("inc_after_clr", cnt_of(0), 32'd1);
    req_valid = 4'b0000;
    repeat (3) @(negedge clk);

    // Reset mid-stream with both stages full; pointer becomes 1 before reset.
    req_valid = 4'b0001;
    req_data  = 64'h0000_0000_0000_0005;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    #2;
    i_nrst = 1'b0;
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_out_data", {24'd0, out_data}, 32'd0);
    check("midrst_sat_cnt", sat_cnt, 32'd0);
    req_valid = 4'b1001;
    @(negedge clk);
    i_nrst = 1'b1;
    #1;
    check("post_rst_grant", {28'd0, req_ready}, 32'h1);
    @(negedge clk);
    check("post_rst_no_stale", {31'd0, out_valid}, 32'd0);
    check("post_rst_grant3", {28'd0, req_ready}, 32'h8);
    @(negedge clk);
    req_valid = 4'b0000;
    check("post_rst_out_valid", {31'd0, out_valid}, 32'd1);
    check("post_rst_out_ch", {30'd0, out_ch}, 32'd0);
    check("post_rst_out_data", {24'd0, out_data}, 32'h05);
    @(negedge clk);
    check("post_rst_out_ch3", {30'd0, out_ch}, 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
